sram22_port_master: RTL and testbench

- Initiator-side controller for a single-port sram22 macro: clk, we, wmask, addr, din, dout.
- Presents a valid/ready request channel with byte strobes and a valid/ready read-response channel to the rest of the design.
- Sequences accesses onto the SRAM port, expands byte strobes to the macro's nibble write mask, and captures the registered read data one cycle after issue.
- Buffers read data in a credit-checked response FIFO, so response backpressure never loses or overwrites data.

---
 rtl/sram22_pkg.sv | 35 +++
 rtl/sram22_resp_fifo.sv | 57 +++++
 rtl/sram22_port_master.sv | 96 +++++++++
 tb/tb_sram22_port_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_pkg.sv
// Shared constants, request bundle and strobe expansion
// for the sram22 port master and its response FIFO.
package sram22_pkg;

    localparam int SRAM22_DATA_WIDTH  = 32;
    localparam int SRAM22_ADDR_WIDTH  = 9;
    localparam int SRAM22_WMASK_WIDTH = 8;
    localparam int SRAM22_MAX_WMASK   = 64;

    typedef struct packed {
        logic                           we;
        logic [SRAM22_ADDR_WIDTH-1:0]   addr;
        logic [SRAM22_DATA_WIDTH/8-1:0] strb;
        logic [SRAM22_DATA_WIDTH-1:0]   data;
    } sram22_req_t;

    // Each byte strobe fans out to nmask/nbytes adjacent mask bits.
    function automatic logic [SRAM22_MAX_WMASK-1:0] strb_to_wmask(
        input logic [SRAM22_MAX_WMASK-1:0] strb,
        input int                          nbytes,
        input int                          nmask
    );
        logic [SRAM22_MAX_WMASK-1:0] m;
        int per;
        m   = '0;
        per = nmask / nbytes;
        for (int k = 0; k < SRAM22_MAX_WMASK; k++) begin
            if (k < nmask) begin
                m[6'(k)] = strb[6'(k / per)];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sram22_resp_fifo.sv
// Read-response FIFO: head read straight from storage flops,
// simultaneous push/pop allowed at any occupancy.
module sram22_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

    // Credit check upstream makes a push into a full FIFO impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CW'(DEPTH)))
    );

endmodule

// File: rtl/sram22_port_master.sv
// Initiator for a single-port sram22 macro: issues requests
// combinationally and buffers read data in a credited FIFO.
module sram22_port_master
    import sram22_pkg::*;
#(
    parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
    parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
    parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    sram_we,
    output logic [WMASK_WIDTH-1:0]  sram_wmask,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic                  rd_inflight;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] head;
    logic [CW:0]           occ;
    logic                  pop;
    logic                  rd_ok;
    logic                  accept;
    logic                  wr_issue;
    logic                  rd_issue;

    assign resp_valid = RST_N && (count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = head;

    // Slots already owed: stored entries plus the read whose data lands next edge.
    assign occ   = {1'b0, count} + (CW+1)'(rd_inflight) - (CW+1)'(pop);
    assign rd_ok = occ < (CW+1)'(RESP_DEPTH);

    assign req_ready = RST_N && (req_we || rd_ok);
    assign accept    = req_valid && req_ready;
    assign wr_issue  = accept && req_we;
    assign rd_issue  = accept && !req_we;

    always_comb begin
        sram_we    = wr_issue;
        sram_wmask = '0;
        sram_din   = '0;
        sram_addr  = addr_q;
        if (accept) begin
            sram_addr = req_addr;
        end
        if (wr_issue) begin
            sram_din   = req_data;
            sram_wmask = WMASK_WIDTH'(strb_to_wmask(
                SRAM22_MAX_WMASK'(req_strb), NB, WMASK_WIDTH));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_inflight <= 1'b0;
            addr_q      <= '0;
        end else begin
            rd_inflight <= rd_issue;
            if (accept) begin
                addr_q <= req_addr;
            end
        end
    end

    sram22_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (rd_inflight),
        .push_data (sram_dout),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_sram22_port_master.sv
// Directed bench for sram22_port_master with a behavioural
// sram22 macro and an in-order response scoreboard.
module tb_sram22_port_master;
    import sram22_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        sram_we;
    logic [7:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          exact;
    } exp_t;
    exp_t q[$];

    typedef struct {
        sram22_req_t req;
        logic [7:0]  wm;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[13];

    logic [31:0] mem [512];

    sram22_port_master dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_strb   (req_strb),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        sram_dout = '0;
    end

    // Macro model: nibble-masked write, registered read, garbage after write.
    always @(posedge CLK) begin
        logic [31:0] w;
        if (sram_we) begin
            w = mem[sram_addr];
            for (int k = 0; k < 8; k++)
                if (sram_wmask[k]) w[4*k +: 4] = sram_din[4*k +: 4];
            mem[sram_addr] <= w;
            sram_dout <= 32'hBAD0BAD0;
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        #2;
        if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("resp_data", 64'(resp_data), 64'(e.data));
                if (e.exact) chk("resp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic set_req(input logic v, input logic we, input logic [8:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_strb  = s;
        req_data  = d;
    endtask

    task automatic expect_read(input logic [31:0] d, input bit exact);
        exp_t e;
        e.data  = d;
        e.cyc   = cyc + 2;
        e.exact = exact;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    function automatic sram22_req_t mk(input logic we, input logic [8:0] a,
                                      input logic [3:0] s, input logic [31:0] d);
        sram22_req_t r;
        r.we = we; r.addr = a; r.strb = s; r.data = d;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        checks   = 0;
        failures = 0;
        cyc      = 0;

        vecs[0]  = '{mk(1, 9'd3,  4'hF, 32'hDEADBEEF), 8'hFF, 32'h0};
        vecs[1]  = '{mk(0, 9'd3,  4'h0, 32'h0),        8'h00, 32'hDEADBEEF};
        vecs[2]  = '{mk(1, 9'd7,  4'hF, 32'h11223344), 8'hFF, 32'h0};
        vecs[3]  = '{mk(1, 9'd7,  4'h5, 32'hAABBCCDD), 8'h33, 32'h0};
        vecs[4]  = '{mk(0, 9'd7,  4'h0, 32'h0),        8'h00, 32'h11BB33DD};
        vecs[5]  = '{mk(1, 9'd9,  4'hF, 32'h12345678), 8'hFF, 32'h0};
        vecs[6]  = '{mk(1, 9'd9,  4'h0, 32'hFFFFFFFF), 8'h00, 32'h0};
        vecs[7]  = '{mk(0, 9'd9,  4'h0, 32'h0),        8'h00, 32'h12345678};
        vecs[8]  = '{mk(1, 9'd10, 4'h8, 32'hCAFEF00D), 8'hC0, 32'h0};
        vecs[9]  = '{mk(0, 9'd10, 4'h0, 32'h0),        8'h00, 32'hCA000000};
        vecs[10] = '{mk(0, 9'd3,  4'h0, 32'h0),        8'h00, 32'hDEADBEEF};
        vecs[11] = '{mk(1, 9'd3,  4'h2, 32'h0),        8'h0C, 32'h0};
        vecs[12] = '{mk(0, 9'd3,  4'h0, 32'h0),        8'h00, 32'hDEAD00EF};

        RST_N      = 1'b0;
        resp_ready = 1'b1;
        set_req(1, 1, 9'd1, 4'hF, 32'hFFFFFFFF);
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_sram_we", 64'(sram_we), 0);
        chk("rst_sram_wmask", 64'(sram_wmask), 0);
        chk("rst_sram_din", 64'(sram_din), 0);

        // Read accepted, then reset in the data-return cycle.
        @(negedge CLK);
        RST_N = 1'b1;
        set_req(1, 0, 9'd5, 4'h0, 32'h0);
        #1;
        chk("rd5_ready", 64'(req_ready), 1);
        chk("rd5_addr", 64'(sram_addr), 64'd5);
        @(negedge CLK);
        RST_N = 1'b0;
        set_req(0, 0, 9'd0, 4'h0, 32'h0);
        #1;
        chk("rst2_req_ready", 64'(req_ready), 0);
        chk("rst2_resp_valid", 64'(resp_valid), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_held_addr", 64'(sram_addr), 0);
        for (int i = 0; i < 5; i++) begin
            chk("discarded_read", 64'(resp_valid), 0);
            @(negedge CLK);
            #1;
        end

        // Table of back-to-back issue-path vectors.
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            set_req(1, vecs[i].req.we, vecs[i].req.addr,
                    vecs[i].req.strb, vecs[i].req.data);
            #1;
            chk("vec_ready", 64'(req_ready), 1);
            chk("vec_we", 64'(sram_we), 64'(vecs[i].req.we));
            chk("vec_wmask", 64'(sram_wmask), 64'(vecs[i].wm));
            chk("vec_addr", 64'(sram_addr), 64'(vecs[i].req.addr));
            chk("vec_din", 64'(sram_din),
                vecs[i].req.we ? 64'(vecs[i].req.data) : 64'd0);
            if (!vecs[i].req.we && req_ready) expect_read(vecs[i].rdata, 1);
        end
        @(negedge CLK);
        set_req(0, 0, 9'd0, 4'h0, 32'h0);
        #1;
        chk("idle_we", 64'(sram_we), 0);
        chk("idle_wmask", 64'(sram_wmask), 0);
        chk("idle_din", 64'(sram_din), 0);
        chk("idle_addr_hold", 64'(sram_addr), 64'd3);
        drain("table_drain");

        // Backpressure: only RESP_DEPTH reads fit while resp_ready is low.
        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            logic [8:0]  a;
            logic [31:0] d;
            case (i)
                0: begin a = 9'd7;  d = 32'h11BB33DD; end
                1: begin a = 9'd9;  d = 32'h12345678; end
                2: begin a = 9'd10; d = 32'hCA000000; end
                default: begin a = 9'd3; d = 32'hDEAD00EF; end
            endcase
            @(negedge CLK);
            set_req(1, 0, a, 4'h0, 32'h0);
            #1;
            chk("bp_ready", 64'(req_ready), (i < 2) ? 64'd1 : 64'd0);
            if (req_ready) begin
                acc++;
                expect_read(d, 0);
            end
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        @(negedge CLK);
        set_req(1, 1, 9'd11, 4'hF, 32'h01020304);
        #1;
        chk("bp_write_ready", 64'(req_ready), 1);
        chk("bp_write_we", 64'(sram_we), 1);
        @(negedge CLK);
        set_req(1, 0, 9'd3, 4'h0, 32'h0);
        #1;
        chk("bp_read_blocked", 64'(req_ready), 0);
        chk("bp_blocked_we", 64'(sram_we), 0);
        chk("bp_blocked_addr", 64'(sram_addr), 64'd11);
        chk("bp_head_valid", 64'(resp_valid), 1);
        chk("bp_head_data", 64'(resp_data), 64'h11BB33DD);
        @(negedge CLK);
        set_req(0, 0, 9'd0, 4'h0, 32'h0);
        resp_ready = 1'b1;
        drain("bp_drain");
        set_req(1, 0, 9'd11, 4'h0, 32'h0);
        #1;
        chk("bp_resume_ready", 64'(req_ready), 1);
        if (req_ready) expect_read(32'h01020304, 1);
        @(negedge CLK);
        set_req(0, 0, 9'd0, 4'h0, 32'h0);
        drain("resume_drain");

        // Streaming: prefill, then 100 random reads at one per cycle.
        for (int a = 32; a < 64; a++) begin
            @(negedge CLK);
            set_req(1, 1, 9'(a), 4'hF, 32'hC0DE0000 | 32'(a));
        end
        for (int i = 0; i < 100; i++) begin
            int a;
            a = 32 + int'($urandom_range(0, 31));
            @(negedge CLK);
            set_req(1, 0, 9'(a), 4'h0, 32'h0);
            #1;
            chk("stream_ready", 64'(req_ready), 1);
            if (req_ready) expect_read(32'hC0DE0000 | 32'(a), 1);
        end
        @(negedge CLK);
        set_req(0, 0, 9'd0, 4'h0, 32'h0);
        drain("stream_drain");

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
